// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle sequencer for the MIPS datapath. It owns the PC and the
// instruction register, steps one phase per cycle and resolves beq/j.
// Memory accesses wait on a handshake that is bounded by a timeout.
module mips_multicycle_sequencer #(
  parameter logic [31:0] PC_RESET    = 32'd0,
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr_in,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_load,
  output logic        reg_read_en,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_write,
  output logic        reg_write_en,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [5:0]  OP_RTYPE  = 6'b000000;
  localparam logic [5:0]  OP_ADDI   = 6'b001000;
  localparam logic [5:0]  OP_LW     = 6'b100011;
  localparam logic [5:0]  OP_SW     = 6'b101011;
  localparam logic [5:0]  OP_BEQ    = 6'b000100;
  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        error_q, error_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ir_load_q, ir_load_d;
  logic        reg_read_en_q, reg_read_en_d;
  logic        alu_en_q, alu_en_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic        reg_write_en_q, reg_write_en_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;

  // Retired-instruction counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : (value + 16'd1);
  endfunction

  // Next state, PC/IR/counter updates and output decode of the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tmo_d   = 8'd0;
    error_d = error_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = PC_RESET;
          error_d = 1'b0;
          cnt_d   = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        ir_d = instr_in;
        if (instr_in == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (ir_q[31:26])
          OP_RTYPE, OP_ADDI: state_d = S_WRITEBACK;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ: begin
            if (alu_zero) begin
              pc_d = pc_q + PC_STEP + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
            end else begin
              pc_d = pc_q + PC_STEP;
            end
            cnt_d   = sat_inc(cnt_q);
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            cnt_d   = sat_inc(cnt_q);
            state_d = S_FETCH;
          end
          default: begin
            error_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (ir_q[31:26] == OP_LW) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_d    = pc_q + PC_STEP;
            cnt_d   = sat_inc(cnt_q);
            state_d = S_FETCH;
          end
        end else if (tmo_q == (MEM_TIMEOUT - 8'd1)) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + PC_STEP;
        cnt_d   = sat_inc(cnt_q);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    ir_load_d      = (state_d == S_FETCH);
    reg_read_en_d  = (state_d == S_DECODE);
    alu_en_d       = (state_d == S_EXECUTE);
    mem_req_d      = (state_d == S_MEM);
    mem_write_d    = (state_d == S_MEM) && (ir_d[31:26] == OP_SW);
    reg_write_en_d = (state_d == S_WRITEBACK);
    busy_d         = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d       = (state_d == S_HALT);
  end

  // Sequencer state and registered outputs; reset aborts any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= PC_RESET;
      ir_q           <= 32'd0;
      tmo_q          <= 8'd0;
      error_q        <= 1'b0;
      cnt_q          <= 16'd0;
      ir_load_q      <= 1'b0;
      reg_read_en_q  <= 1'b0;
      alu_en_q       <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_write_q    <= 1'b0;
      reg_write_en_q <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      tmo_q          <= tmo_d;
      error_q        <= error_d;
      cnt_q          <= cnt_d;
      ir_load_q      <= ir_load_d;
      reg_read_en_q  <= reg_read_en_d;
      alu_en_q       <= alu_en_d;
      mem_req_q      <= mem_req_d;
      mem_write_q    <= mem_write_d;
      reg_write_en_q <= reg_write_en_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
    end
  end

  assign pc           = pc_q;
  assign ir           = ir_q;
  assign ir_load      = ir_load_q;
  assign reg_read_en  = reg_read_en_q;
  assign alu_en       = alu_en_q;
  assign mem_req      = mem_req_q;
  assign mem_write    = mem_write_q;
  assign reg_write_en = reg_write_en_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign error        = error_q;
  assign instr_count  = cnt_q;

endmodule

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Multi-cycle controller that drives the existing single-cycle MIPS datapath (instruction memory, control unit, register file, ALU, main memory) one phase at a time.
- Owns the program counter and latches the current instruction.
- Issues one enable per phase, waits on the main-memory handshake, and resolves branches and jumps.
- Sits between the testbench/top level and the datapath. The datapath's state elements update only when this block enables them.

Parameters:
- PC_RESET, 32'd0: PC value loaded on reset and on start.
- PC_STEP, 32'd4: PC increment per sequential instruction.
- MEM_TIMEOUT, 8'd15: maximum cycles in MEM waiting for mem_ready before an error is raised.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; starts execution from PC_RESET when in IDLE or HALT.
- instr_in  input  32  instruction-memory output for the current pc (combinational).
- alu_zero  input  1  ALU zero flag, valid during EXECUTE.
- mem_ready  input  1  main memory has completed the requested access.
- pc  output  32  program counter fed to instruction memory.
- ir  output  32  latched instruction driving the control unit and register addresses.
- ir_load  output  1  high in FETCH.
- reg_read_en  output  1  high in DECODE.
- alu_en  output  1  high in EXECUTE.
- mem_req  output  1  high in MEM until the handshake completes.
- mem_write  output  1  high with mem_req for sw; low for lw.
- reg_write_en  output  1  high in WRITEBACK.
- busy  output  1  high in any state except IDLE and HALT.
- halted  output  1  high in HALT.
- error  output  1  sticky; set on illegal opcode or memory timeout.
- instr_count  output  16  number of retired instructions; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n low), all outputs take these values immediately:
  - state = IDLE, pc = PC_RESET, ir = 0.
  - All enables 0; busy = 0, halted = 0, error = 0, instr_count = 0.
  - Internal timeout counter cleared.
  - A reset asserted mid-instruction aborts that instruction. No writeback or memory request is issued afterwards.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Registered outputs are decoded from the state.
- IDLE: start → FETCH, with pc = PC_RESET, error cleared and instr_count cleared.
- FETCH (1 cycle): ir <= instr_in.
  - If instr_in == 32'hFFFFFFFF → HALT; the halt word is not counted.
  - Otherwise → DECODE.
- DECODE (1 cycle): → EXECUTE.
- EXECUTE (1 cycle), by ir[31:26]:
  - 000000 R-type, 001000 addi: → WRITEBACK.
  - 100011 lw: → MEM, mem_write = 0.
  - 101011 sw: → MEM, mem_write = 1.
  - 000100 beq: retire.
    - alu_zero = 1: pc <= pc + PC_STEP + (sign_extend(ir[15:0]) << 2).
    - alu_zero = 0: pc <= pc + PC_STEP.
    - → FETCH.
  - 000010 j: retire; pc <= {pc[31:28], ir[25:0], 2'b00}; → FETCH.
  - Any other opcode: error <= 1; → HALT; not retired.
- MEM:
  - mem_req is held high until mem_ready is sampled high on a rising edge. mem_ready high on the first MEM cycle completes the access in 1 cycle.
  - On completion, lw → WRITEBACK. sw retires: pc += PC_STEP; → FETCH.
  - mem_ready is ignored outside MEM.
  - The timeout counter counts MEM cycles. If MEM_TIMEOUT cycles pass without mem_ready: error <= 1, mem_req drops, → HALT.
- WRITEBACK (1 cycle): retire; pc += PC_STEP; → FETCH.
- Retire means instr_count += 1, saturating at 16'hFFFF.
- Latencies with zero-wait memory:
  - R-type/addi: 4 cycles.
  - beq/j: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- PC arithmetic is modulo 2^32; wrap-around is silent.
- HALT: outputs held; start → FETCH from PC_RESET, with error and instr_count cleared.
- start is ignored while busy.

Test Plan:
- Reset then start, program {add, addi, 32'hFFFFFFFF}:
  - pc sequence 0, 4, 8.
  - reg_write_en pulses exactly twice, each 4 cycles apart.
  - halted = 1, instr_count = 2, error = 0.
- lw with mem_ready delayed 3 cycles:
  - mem_req high for exactly 4 cycles, mem_write = 0.
  - reg_write_en asserts the cycle after mem_ready; pc advances by 4.
- beq with alu_zero = 1, offset 16'hFFFE at pc 8 → next pc = 4.
- Same beq with alu_zero = 0 → next pc = 12.
- j with ir[25:0] = 26'd5 at pc 32'h1000_0000 → next pc = 32'h1000_0014.
- sw with mem_ready held low: after 15 MEM cycles, error = 1, halted = 1, mem_req = 0, instr_count unchanged.
- Opcode 6'b111110 → error = 1, halted.
- rst_n pulsed low during MEM of a lw: outputs go to reset values immediately; no reg_write_en pulse follows.
